// File: rtl/vga_frame_signature.sv
// Per-frame CRC-32 signature and geometry checker for a VGA R/G/B stream.
// Optional `define VGA_SIG_COMPARE_EN adds SIG_CHANGED against the previous frame's signature.
module vga_frame_signature #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned COLOR_W  = 8,
  parameter int unsigned CNT_W    = 11
) (
  input  logic               CLOCK_25,
  input  logic               RESET_N,
  input  logic               PIX_EN,
  input  logic               VGA_VS,
  input  logic               VGA_BLANK_N,
  input  logic [COLOR_W-1:0] VGA_R,
  input  logic [COLOR_W-1:0] VGA_G,
  input  logic [COLOR_W-1:0] VGA_B,
  input  logic               ARM,
  input  logic               CONT,
  output logic [31:0]        SIGNATURE,
  output logic               SIG_VALID,
  output logic [CNT_W-1:0]   LINE_COUNT,
  output logic               ERR_HLEN,
  output logic               ERR_VLEN,
`ifdef VGA_SIG_COMPARE_EN
  output logic               SIG_CHANGED,
`endif
  output logic               BUSY
);

  localparam int unsigned    PixW = 3 * COLOR_W;
  localparam logic [31:0]    Poly = 32'h04C1_1DB7;
  localparam logic [CNT_W-1:0] HAct = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VAct = CNT_W'(V_ACTIVE);

  typedef enum logic [1:0] {StIdle, StWaitVs, StCapture, StDone} state_e;

  state_e             state_q, state_d;
  logic               vs_q, vs_d;
  logic               blank_q, blank_d;
  logic [31:0]        crc_q, crc_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]   line_cnt_q, line_cnt_d;
  logic [31:0]        signature_q, signature_d;
  logic               sig_valid_q, sig_valid_d;
  logic [CNT_W-1:0]   line_count_q, line_count_d;
  logic               err_hlen_q, err_hlen_d;
  logic               err_vlen_q, err_vlen_d;
`ifdef VGA_SIG_COMPARE_EN
  logic [31:0]        prev_sig_q, prev_sig_d;
  logic               sig_changed_q, sig_changed_d;
`endif

  logic               fb;
  logic               eol;
  logic [PixW-1:0]    pixel;
  logic [CNT_W-1:0]   pix_inc;
  logic [CNT_W-1:0]   line_inc;
  logic [CNT_W-1:0]   line_fin;

  // Whole pixel folded MSB first in one cycle.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [PixW-1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = PixW - 1; i >= 0; i--) begin
      c = {c[30:0], 1'b0} ^ ((c[31] ^ d[i]) ? Poly : 32'h0);
    end
    return c;
  endfunction

  always_comb begin
    pixel    = {VGA_B, VGA_G, VGA_R};
    fb       = PIX_EN & ~VGA_VS & vs_q;
    eol      = PIX_EN & ~VGA_BLANK_N & blank_q;
    pix_inc  = (pix_cnt_q == '1) ? pix_cnt_q : pix_cnt_q + 1'b1;
    line_inc = (line_cnt_q == '1) ? line_cnt_q : line_cnt_q + 1'b1;
    // A line that ends on the boundary sample itself still counts.
    line_fin = eol ? line_inc : line_cnt_q;

    state_d      = state_q;
    vs_d         = vs_q;
    blank_d      = blank_q;
    crc_d        = crc_q;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    signature_d  = signature_q;
    sig_valid_d  = 1'b0;
    line_count_d = line_count_q;
    err_hlen_d   = err_hlen_q;
    err_vlen_d   = err_vlen_q;
`ifdef VGA_SIG_COMPARE_EN
    prev_sig_d    = prev_sig_q;
    sig_changed_d = sig_changed_q;
`endif

    if (PIX_EN) begin
      vs_d    = VGA_VS;
      blank_d = VGA_BLANK_N;
    end

    unique case (state_q)
      StIdle: begin
        if (ARM) begin
          state_d    = StWaitVs;
          err_hlen_d = 1'b0;
          err_vlen_d = 1'b0;
        end
      end
      StWaitVs: begin
        if (fb) begin
          crc_d      = '1;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          state_d    = StCapture;
        end
      end
      StCapture: begin
        if (fb) begin
          if (eol && (pix_cnt_q != HAct)) err_hlen_d = 1'b1;
          if (line_fin != VAct) err_vlen_d = 1'b1;
          signature_d  = crc_q;
          line_count_d = line_fin;
          sig_valid_d  = 1'b1;
`ifdef VGA_SIG_COMPARE_EN
          sig_changed_d = (crc_q != prev_sig_q);
          prev_sig_d    = crc_q;
`endif
          crc_d      = '1;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          state_d    = CONT ? StCapture : StDone;
        end else if (PIX_EN && VGA_BLANK_N) begin
          crc_d     = crc_step(crc_q, pixel);
          pix_cnt_d = pix_inc;
        end else if (eol) begin
          if (pix_cnt_q != HAct) err_hlen_d = 1'b1;
          line_cnt_d = line_inc;
          pix_cnt_d  = '0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= StIdle;
      vs_q         <= 1'b1;
      blank_q      <= 1'b0;
      crc_q        <= '1;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      signature_q  <= '0;
      sig_valid_q  <= 1'b0;
      line_count_q <= '0;
      err_hlen_q   <= 1'b0;
      err_vlen_q   <= 1'b0;
`ifdef VGA_SIG_COMPARE_EN
      prev_sig_q    <= '0;
      sig_changed_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      vs_q         <= vs_d;
      blank_q      <= blank_d;
      crc_q        <= crc_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      signature_q  <= signature_d;
      sig_valid_q  <= sig_valid_d;
      line_count_q <= line_count_d;
      err_hlen_q   <= err_hlen_d;
      err_vlen_q   <= err_vlen_d;
`ifdef VGA_SIG_COMPARE_EN
      prev_sig_q    <= prev_sig_d;
      sig_changed_q <= sig_changed_d;
`endif
    end
  end

  assign SIGNATURE  = signature_q;
  assign SIG_VALID  = sig_valid_q;
  assign LINE_COUNT = line_count_q;
  assign ERR_HLEN   = err_hlen_q;
  assign ERR_VLEN   = err_vlen_q;
  assign BUSY       = (state_q == StWaitVs) || (state_q == StCapture);
`ifdef VGA_SIG_COMPARE_EN
  assign SIG_CHANGED = sig_changed_q;
`endif

endmodule

// File: tb/tb_vga_frame_signature.sv
// Self-checking bench for vga_frame_signature: small 4x3 geometry, table-driven CRC reference.
module tb_vga_frame_signature;

  localparam int H = 4;
  localparam int V = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic        vs = 1'b1;
  logic        blank = 1'b0;
  logic [7:0]  r = 8'h0, g = 8'h0, b = 8'h0;
  logic        arm = 1'b0;
  logic        cont = 1'b0;
  logic [31:0] signature;
  logic        sig_valid;
  logic [10:0] line_count;
  logic        err_hlen, err_vlen, busy;
`ifdef VGA_SIG_COMPARE_EN
  logic        sig_changed;
`endif

  vga_frame_signature #(.H_ACTIVE(H), .V_ACTIVE(V), .COLOR_W(8), .CNT_W(11)) dut (
    .CLOCK_25   (clk),
    .RESET_N    (rst_n),
    .PIX_EN     (pix_en),
    .VGA_VS     (vs),
    .VGA_BLANK_N(blank),
    .VGA_R      (r),
    .VGA_G      (g),
    .VGA_B      (b),
    .ARM        (arm),
    .CONT       (cont),
    .SIGNATURE  (signature),
    .SIG_VALID  (sig_valid),
    .LINE_COUNT (line_count),
    .ERR_HLEN   (err_hlen),
    .ERR_VLEN   (err_vlen),
`ifdef VGA_SIG_COMPARE_EN
    .SIG_CHANGED(sig_changed),
`endif
    .BUSY       (busy)
  );

  always #20 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          div = 1;
  int          mode = 0;
  int          pidx = 0;
  logic [31:0] model_crc;
  logic [31:0] tbl [256];
  logic [23:0] pix_mem [64];
  logic [31:0] exp_q [$];
  logic [31:0] sv_sig [$];
  logic        sv_chg [$];

  always @(negedge clk) begin
    if (sig_valid) begin
      sv_sig.push_back(signature);
`ifdef VGA_SIG_COMPARE_EN
      sv_chg.push_back(sig_changed);
`else
      sv_chg.push_back(1'b0);
`endif
    end
  end

  // Byte-wise table CRC; a pixel is the three bytes B, G, R in that order.
  function automatic logic [31:0] crc_px(input logic [31:0] crc, input logic [23:0] px);
    logic [31:0] c;
    logic [7:0]  byt;
    c = crc;
    for (int k = 0; k < 3; k++) begin
      byt = 8'(px >> (16 - 8 * k));
      c = (c << 8) ^ tbl[c[31:24] ^ byt];
    end
    return c;
  endfunction

  task automatic build_table();
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i) << 24;
      for (int j = 0; j < 8; j++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
      tbl[i] = c;
    end
  endtask

  task automatic sample(input logic v, input logic bl, input logic [23:0] px);
    @(negedge clk);
    vs = v; blank = bl; {b, g, r} = px; pix_en = 1'b1;
    if (div == 2) begin
      @(negedge clk);
      pix_en = 1'b0;
    end
  endtask

  task automatic fb();
    sample(1'b0, 1'b0, 24'h0);
    sample(1'b0, 1'b0, 24'h0);
    sample(1'b1, 1'b0, 24'h0);
    sample(1'b1, 1'b0, 24'h0);
  endtask

  task automatic start_frame();
    model_crc = 32'hFFFF_FFFF;
    pidx = 0;
  endtask

  task automatic gen_line(input int len);
    logic [23:0] px;
    for (int p = 0; p < len; p++) begin
      case (mode)
        0: px = 24'h0;
        1: begin px = 24'($urandom); pix_mem[pidx] = px; end
        2: px = pix_mem[pidx];
        default: px = {8'(3 * pidx), 8'(2 * pidx + 7), 8'(pidx)};
      endcase
      pidx++;
      sample(1'b1, 1'b1, px);
      model_crc = crc_px(model_crc, px);
    end
    sample(1'b1, 1'b0, 24'h0);
    sample(1'b1, 1'b0, 24'h0);
  endtask

  task automatic do_arm();
    @(negedge clk);
    pix_en = 1'b0; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    pix_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #5;
    checks++; if (signature !== 32'h0) begin errors++; $display("FAIL reset_sig got %h want 0", signature); end
    checks++; if (sig_valid !== 1'b0) begin errors++; $display("FAIL reset_sv got %b want 0", sig_valid); end
    checks++; if (line_count !== 11'd0) begin errors++; $display("FAIL reset_lc got %0d want 0", line_count); end
    checks++; if ({err_hlen, err_vlen, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {err_hlen, err_vlen, busy}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_geometry();
    logic [31:0] e;
    sv_sig.delete();
    mode = 0;
    do_arm();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL geo_busy_armed got %b want 1", busy); end
    fb();
    start_frame();
    for (int l = 0; l < V; l++) gen_line(H);
    e = model_crc;
    fb();
    start_frame();
    for (int l = 0; l < V; l++) gen_line(H);
    fb();
    settle();
    checks++; if (sv_sig.size() != 1) begin errors++; $display("FAIL geo_sv_count got %0d want 1", sv_sig.size()); end
    else begin
      checks++; if (sv_sig[0] !== e) begin errors++; $display("FAIL geo_sig got %h want %h", sv_sig[0], e); end
    end
    checks++; if (signature !== e) begin errors++; $display("FAIL geo_sig_hold got %h want %h", signature, e); end
    checks++; if (line_count !== 11'(V)) begin errors++; $display("FAIL geo_lc got %0d want %0d", line_count, V); end
    checks++; if ({err_hlen, err_vlen} !== 2'b00) begin errors++; $display("FAIL geo_err got %b want 00", {err_hlen, err_vlen}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL geo_busy_end got %b want 0", busy); end
  endtask

  task automatic test_short_line();
    logic [31:0] e;
    sv_sig.delete();
    mode = 1;
    do_arm();
    fb();
    start_frame();
    gen_line(H);
    checks++; if (err_hlen !== 1'b0) begin errors++; $display("FAIL short_pre got %b want 0", err_hlen); end
    gen_line(H - 1);
    checks++; if (err_hlen !== 1'b1) begin errors++; $display("FAIL short_hlen got %b want 1", err_hlen); end
    gen_line(H);
    e = model_crc;
    fb();
    settle();
    checks++; if (err_hlen !== 1'b1) begin errors++; $display("FAIL short_hlen_sticky got %b want 1", err_hlen); end
    checks++; if (err_vlen !== 1'b0) begin errors++; $display("FAIL short_vlen got %b want 0", err_vlen); end
    checks++; if (line_count !== 11'(V)) begin errors++; $display("FAIL short_lc got %0d want %0d", line_count, V); end
    checks++; if (signature !== e) begin errors++; $display("FAIL short_sig got %h want %h", signature, e); end
    do_arm();
    checks++; if (err_hlen !== 1'b0) begin errors++; $display("FAIL short_clear got %b want 0", err_hlen); end
  endtask

  task automatic test_extra_line();
    logic [31:0] e;
    mode = 1;
    do_arm();
    fb();
    start_frame();
    for (int l = 0; l < V + 1; l++) gen_line(H);
    e = model_crc;
    fb();
    settle();
    checks++; if (line_count !== 11'(V + 1)) begin errors++; $display("FAIL extra_lc got %0d want %0d", line_count, V + 1); end
    checks++; if (err_vlen !== 1'b1) begin errors++; $display("FAIL extra_vlen got %b want 1", err_vlen); end
    checks++; if (err_hlen !== 1'b0) begin errors++; $display("FAIL extra_hlen got %b want 0", err_hlen); end
    checks++; if (signature !== e) begin errors++; $display("FAIL extra_sig got %h want %h", signature, e); end
  endtask

  task automatic test_pix_div();
    logic [31:0] e;
    mode = 1;
    do_arm();
    fb();
    start_frame();
    for (int l = 0; l < V; l++) gen_line(H);
    e = model_crc;
    fb();
    settle();
    checks++; if (signature !== e) begin errors++; $display("FAIL div1_sig got %h want %h", signature, e); end
    div = 2;
    mode = 2;
    sv_sig.delete();
    do_arm();
    fb();
    start_frame();
    for (int l = 0; l < V; l++) gen_line(H);
    fb();
    settle();
    div = 1;
    checks++; if (sv_sig.size() != 1) begin errors++; $display("FAIL div2_sv_count got %0d want 1", sv_sig.size()); end
    checks++; if (signature !== e) begin errors++; $display("FAIL div2_sig got %h want %h", signature, e); end
    checks++; if ({err_hlen, err_vlen} !== 2'b00) begin errors++; $display("FAIL div2_err got %b want 00", {err_hlen, err_vlen}); end
  endtask

  task automatic test_cont();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    sv_sig.delete(); sv_chg.delete(); exp_q.delete();
    mode = 3;
    cont = 1'b1;
    do_arm();
    fb();
    for (int f = 0; f < 3; f++) begin
      start_frame();
      for (int l = 0; l < V; l++) gen_line(H);
      exp_q.push_back(model_crc);
      if (f == 2) cont = 1'b0;
      fb();
    end
    settle();
    checks++; if (sv_sig.size() != 3) begin errors++; $display("FAIL cont_sv_count got %0d want 3", sv_sig.size()); end
    else begin
      for (int f = 0; f < 3; f++) begin
        checks++; if (sv_sig[f] !== exp_q[f]) begin
          errors++; $display("FAIL cont_sig%0d got %h want %h", f, sv_sig[f], exp_q[f]); end
`ifdef VGA_SIG_COMPARE_EN
        checks++; if (sv_chg[f] !== (f == 0)) begin
          errors++; $display("FAIL cont_changed%0d got %b want %b", f, sv_chg[f], f == 0); end
`endif
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    mode = 1;
    do_arm();
    fb();
    start_frame();
    gen_line(H);
    sample(1'b1, 1'b1, 24'h123456);
    sample(1'b1, 1'b1, 24'h654321);
    sv_sig.delete();
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({signature, line_count} !== 43'h0) begin
      errors++; $display("FAIL rstmid_regs got %h/%0d want 0/0", signature, line_count); end
    checks++; if ({sig_valid, err_hlen, err_vlen, busy} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_flags got %b want 0000", {sig_valid, err_hlen, err_vlen, busy}); end
    pix_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (sv_sig.size() != 0) begin errors++; $display("FAIL rstmid_no_sv got %0d want 0", sv_sig.size()); end
    do_arm();
    fb();
    start_frame();
    for (int l = 0; l < V; l++) gen_line(H);
    e = model_crc;
    fb();
    settle();
    checks++; if (sv_sig.size() != 1) begin errors++; $display("FAIL rstmid_sv_count got %0d want 1", sv_sig.size()); end
    checks++; if (signature !== e) begin errors++; $display("FAIL rstmid_sig got %h want %h", signature, e); end
    checks++; if (line_count !== 11'(V)) begin errors++; $display("FAIL rstmid_lc got %0d want %0d", line_count, V); end
  endtask

  initial begin
    build_table();
    test_reset();
    test_geometry();
    test_short_line();
    test_extra_line();
    test_pix_div();
    test_cont();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
